// File: rtl/next_pc_gen_ras_if.sv
// rtl/next_pc_gen_ras_if.sv - fetch PC generator bundle: redirect, BTB/predictor lookup, PC and RAS checkpoint
interface next_pc_gen_ras_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int RAS_DEPTH   = 8
) ();
  localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int IDX_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
  localparam int CKPT_W = IDX_W + CNT_W;

  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [CKPT_W-1:0]     redirect_ckpt;
  logic                  btb_hit;
  logic [SLOT_W-1:0]     btb_slot;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic                  pred_taken;
  logic [1:0]            pred_kind;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] npc;
  logic [CKPT_W-1:0]     ras_ckpt;
  logic                  ras_overflow;

  // Frontend/backend side: drives lookups and redirects, observes the PC
  modport master (
    output stall, redirect_valid, redirect_pc, redirect_ckpt,
    output btb_hit, btb_slot, btb_target, pred_taken, pred_kind,
    input  pc, npc, ras_ckpt, ras_overflow
  );

  // PC generator side
  modport slave (
    input  stall, redirect_valid, redirect_pc, redirect_ckpt,
    input  btb_hit, btb_slot, btb_target, pred_taken, pred_kind,
    output pc, npc, ras_ckpt, ras_overflow
  );
endinterface

// File: rtl/next_pc_gen_ras.sv
// rtl/next_pc_gen_ras.sv - fetch PC register, next-PC select and checkpointable circular return address stack
module next_pc_gen_ras #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FETCH_WIDTH = 2,
  parameter int                    INST_BYTES  = 4,
  parameter int                    RAS_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  next_pc_gen_ras_if.slave     bus
);
  localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int IDX_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
  localparam int GB     = FETCH_WIDTH * INST_BYTES;
  localparam int OFF_W  = $clog2(INST_BYTES);

  localparam logic [ADDR_WIDTH-1:0] GB_MASK   = ADDR_WIDTH'(GB - 1);
  localparam logic [ADDR_WIDTH-1:0] INST_MASK = ADDR_WIDTH'(INST_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] GB_A      = ADDR_WIDTH'(GB);
  localparam logic [ADDR_WIDTH-1:0] INST_A    = ADDR_WIDTH'(INST_BYTES);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [1:0]            KIND_CALL = 2'b01;
  localparam logic [1:0]            KIND_RET  = 2'b10;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [IDX_W-1:0]      top_q, top_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_WIDTH-1:0] base, slot_pc, ret_pc, npc;
  logic [SLOT_W-1:0]     first_slot;
  logic [IDX_W-1:0]      top_inc;
  logic                  take, is_call, is_ret, ras_empty, ras_full;
  logic                  advance, push, pop;

  // Fetch-group geometry and decode of the BTB/predictor lookup
  always_comb begin
    base       = pc_q & ~GB_MASK;
    first_slot = SLOT_W'((pc_q & GB_MASK) >> OFF_W);
    slot_pc    = base + (ADDR_WIDTH'(bus.btb_slot) << OFF_W);
    // A hit on a slot before the entry point of the group belongs to code we jumped over
    take       = bus.btb_hit & bus.pred_taken & (bus.btb_slot >= first_slot);
    is_call    = (bus.pred_kind == KIND_CALL);
    is_ret     = (bus.pred_kind == KIND_RET);
    ras_empty  = (count_q == '0);
    ras_full   = (count_q == CNT_FULL);
    advance    = !bus.redirect_valid && !bus.stall;
    push       = advance && take && is_call;
    pop        = advance && take && is_ret && !ras_empty;
    top_inc    = top_q + 1'b1;
    ret_pc     = ras_q[top_q];
  end

  // Next fetch address: redirect > stall > RAS return > BTB target > sequential
  always_comb begin
    npc = base + GB_A;
    if (bus.redirect_valid) begin
      npc = bus.redirect_pc & ~INST_MASK;
    end else if (bus.stall) begin
      npc = pc_q;
    end else if (take && is_ret && !ras_empty) begin
      npc = ret_pc;
    end else if (take) begin
      // Covers returns with an empty stack: fall back to the BTB's guess
      npc = bus.btb_target & ~INST_MASK;
    end
  end

  // RAS pointer/occupancy update; a redirect rewinds to the backend's checkpoint
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (bus.redirect_valid) begin
      {count_d, top_d} = bus.redirect_ckpt;
    end else if (push) begin
      top_d   = top_inc;
      count_d = ras_full ? count_q : count_q + 1'b1;
      ovf_d   = ras_full;
    end else if (pop) begin
      top_d   = top_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // Architectural state: fetch PC, RAS pointers, overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pc_q    <= npc;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAS storage write on call; entries are never cleared, so a full stack overwrites the oldest
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ras_q[top_inc] <= slot_pc + INST_A;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.npc          = npc;
  assign bus.ras_ckpt     = {count_q, top_q};
  assign bus.ras_overflow = ovf_q;
endmodule
